// File: rtl/pellet_tracker.sv
// Pellet tracker: sole port-B client of the map BRAM; eats pellets on tile entry, keeps score and pellet count.
// Power-pellet handling is compiled in only when PELLET_TRACKER_POWER_EN is defined.
module pellet_tracker #(
   parameter int DATA_WIDTH    = 4,
   parameter int DATA_DEPTH    = 1023,
   parameter int MAP_COLS      = 28,
   parameter int EMPTY_CODE    = 0,
   parameter int PELLET_CODE   = 1,
   parameter int POWER_CODE    = 2,
   parameter int TOTAL_PELLETS = 244,
   parameter int SCORE_WIDTH   = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start_level,
   input  logic                                 tile_valid,
   input  logic [4:0]                           tile_x,
   input  logic [5:0]                           tile_y,
   output logic                                 tile_ready,
   output logic                                 map_soft_rst,
   output logic [$clog2(DATA_DEPTH)-1:0]        bram_addr,
   output logic                                 bram_we,
   output logic [DATA_WIDTH-1:0]                bram_wdata,
   input  logic [DATA_WIDTH-1:0]                bram_rdata,
   output logic [SCORE_WIDTH-1:0]               score,
   output logic [$clog2(TOTAL_PELLETS+1)-1:0]   pellets_left,
   output logic                                 power_pulse,
   output logic                                 level_clear,
   output logic [2:0]                           fsm_state
);

   localparam int AW = $clog2(DATA_DEPTH);
   localparam int PW = $clog2(TOTAL_PELLETS + 1);
   localparam int CW = $clog2(DATA_DEPTH + 1);
   localparam logic [CW-1:0]          INIT_LAST  = CW'(DATA_DEPTH);
   localparam logic [SCORE_WIDTH:0]   SCORE_MAX  = {1'b0, {SCORE_WIDTH{1'b1}}};
   localparam logic [SCORE_WIDTH:0]   PELLET_PTS = (SCORE_WIDTH + 1)'(10);
   localparam logic [SCORE_WIDTH:0]   POWER_PTS  = (SCORE_WIDTH + 1)'(50);

   typedef enum logic [2:0] {IDLE, CLEAR, INIT, READY, RD, EVAL, WR, DONE} state_t;

   state_t                 state, next_state;
   logic [CW-1:0]          init_cnt;
   logic [AW-1:0]          addr_q;
   logic                   power_q;
   logic [31:0]            addr_full;
   logic                   in_range;
   logic                   is_pellet, is_power, eat_hit, eat;
   logic [SCORE_WIDTH:0]   score_sum;

   // Handshake: a tile is taken in any cycle where tile_valid && tile_ready;
   // tile_ready is high only in READY, so requests elsewhere are simply ignored.
   assign addr_full = 32'(tile_y) * 32'(MAP_COLS) + 32'(tile_x);
   assign in_range  = (32'(tile_x) < 32'(MAP_COLS)) && (addr_full < 32'(DATA_DEPTH));

   assign is_pellet = (bram_rdata == DATA_WIDTH'(PELLET_CODE));
`ifdef PELLET_TRACKER_POWER_EN
   assign is_power  = (bram_rdata == DATA_WIDTH'(POWER_CODE));
`else
   assign is_power  = 1'b0;
`endif
   assign eat_hit   = is_pellet || is_power;
   // An abort arriving during EVAL cancels the score/count update as well as the write.
   assign eat       = (state == EVAL) && eat_hit && !start_level;
   assign score_sum = {1'b0, score} + (is_power ? POWER_PTS : PELLET_PTS);

   assign bram_addr   = addr_q;
   assign bram_wdata  = DATA_WIDTH'(EMPTY_CODE);
   assign power_pulse = power_q;
   assign fsm_state   = state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         init_cnt     <= '0;
         addr_q       <= '0;
         score        <= '0;
         pellets_left <= '0;
         power_q      <= 1'b0;
      end else begin
         state   <= next_state;
         power_q <= 1'b0;
         case (state)
            CLEAR: begin
               pellets_left <= PW'(TOTAL_PELLETS);
               init_cnt     <= '0;
            end
            INIT:  init_cnt <= init_cnt + 1'b1;
            READY: if (tile_valid && in_range) addr_q <= addr_full[AW-1:0];
            EVAL: begin
               if (eat) begin
                  score   <= (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_WIDTH-1:0]
                                                     : score_sum[SCORE_WIDTH-1:0];
                  power_q <= is_power;
                  if (pellets_left != '0) pellets_left <= pellets_left - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      next_state   = state;
      tile_ready   = 1'b0;
      map_soft_rst = 1'b0;
      bram_we      = 1'b0;
      level_clear  = 1'b0;
      case (state)
         IDLE:  ;
         CLEAR: begin
            map_soft_rst = 1'b1;
            next_state   = INIT;
         end
         INIT:  if (init_cnt == INIT_LAST) next_state = READY;
         READY: begin
            tile_ready = 1'b1;
            if (tile_valid && in_range) next_state = RD;
         end
         RD:    next_state = EVAL;
         EVAL:  next_state = eat_hit ? WR : READY;
         WR: begin
            bram_we    = 1'b1;
            next_state = (pellets_left == '0) ? DONE : READY;
         end
         DONE:  level_clear = 1'b1;
         default: next_state = IDLE;
      endcase
      // start_level wins everywhere; a write in flight is dropped.
      if (start_level) begin
         next_state = CLEAR;
         bram_we    = 1'b0;
      end
   end

endmodule

// File: tb/tb_pellet_tracker.sv
// Bench for pellet_tracker: BRAM model with soft-reset reload, directed steps plus random tile walks
// checked against a tile-map/score reference model.
module tb_pellet_tracker;

   localparam int DEPTH = 1023;
   localparam int COLS  = 28;
   localparam int TOTAL = 244;
   localparam int DW    = 4;
   localparam int SW    = 16;
   localparam int AW    = $clog2(DEPTH);
   localparam int PW    = $clog2(TOTAL + 1);
`ifdef PELLET_TRACKER_POWER_EN
   localparam bit POWER_EN = 1'b1;
`else
   localparam bit POWER_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n, start_level, tile_valid;
   logic [4:0]    tile_x;
   logic [5:0]    tile_y;
   logic          tile_ready, map_soft_rst, bram_we, power_pulse, level_clear;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_wdata, bram_rdata;
   logic [SW-1:0] score;
   logic [PW-1:0] pellets_left;
   logic [2:0]    fsm_state;

   logic [DW-1:0] init_map [0:DEPTH-1];
   logic [DW-1:0] ref_map  [0:DEPTH-1];
   logic [DW-1:0] mem      [0:DEPTH];
   int ref_score = 0;
   int ref_left  = 0;
   int compared  = 0;
   int mismatched = 0;
   int wr_count = 0, pulse_count = 0, srst_count = 0;

   pellet_tracker dut (
      .clk(clk), .rst_n(rst_n), .start_level(start_level),
      .tile_valid(tile_valid), .tile_x(tile_x), .tile_y(tile_y), .tile_ready(tile_ready),
      .map_soft_rst(map_soft_rst), .bram_addr(bram_addr), .bram_we(bram_we),
      .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .score(score),
      .pellets_left(pellets_left), .power_pulse(power_pulse), .level_clear(level_clear),
      .fsm_state(fsm_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   // map BRAM port B with soft-reset reload of the level image
   always @(posedge clk) begin
      if (map_soft_rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= init_map[i];
      end else if (bram_we) begin
         mem[bram_addr] <= bram_wdata;
      end
      bram_rdata <= mem[bram_addr];
   end

   always @(negedge clk) begin
      if (bram_we)      wr_count    <= wr_count + 1;
      if (power_pulse)  pulse_count <= pulse_count + 1;
      if (map_soft_rst) srst_count  <= srst_count + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_score"}, score, 0);
      check({tag, "_left"}, pellets_left, 0);
      check({tag, "_ready"}, tile_ready, 0);
      check({tag, "_srst"}, map_soft_rst, 0);
      check({tag, "_we"}, bram_we, 0);
      check({tag, "_pulse"}, power_pulse, 0);
      check({tag, "_clear"}, level_clear, 0);
      check({tag, "_addr"}, bram_addr, 0);
      check({tag, "_wdata"}, bram_wdata, 0);
   endtask

   // Called in the cycle after start_level was sampled (the CLEAR cycle).
   task automatic after_clear(input string tag);
      int n;
      int s0;
      s0 = srst_count;
      check({tag, "_srst_hi"}, map_soft_rst, 1);
      check({tag, "_clear_drop"}, level_clear, 0);
      check({tag, "_we_clear"}, bram_we, 0);
      check({tag, "_ready_clear"}, tile_ready, 0);
      tick();
      check({tag, "_srst_lo"}, map_soft_rst, 0);
      check({tag, "_left_load"}, pellets_left, TOTAL);
      n = 0;
      while (tile_ready !== 1'b1 && n < DEPTH + 20) begin
         tick();
         n++;
      end
      check({tag, "_init_len"}, n, DEPTH + 1);
      check({tag, "_srst_once"}, srst_count - s0, 1);
      for (int i = 0; i < DEPTH; i++) ref_map[i] = init_map[i];
      ref_left = TOTAL;
   endtask

   task automatic pulse_start(input string tag);
      start_level = 1'b1;
      tick();
      start_level = 1'b0;
      after_clear(tag);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (tile_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("ready_wait", (n < 50), 1);
   endtask

   // Driver + reference model for one tile entry.
   task automatic send_tile(input int x, input int y);
      int a, w0, p0, pts;
      bit disc, eat, pwr;
      logic [DW-1:0] code;
      wait_ready();
      a    = y * COLS + x;
      disc = (x >= COLS) || (a >= DEPTH);
      code = disc ? '0 : ref_map[a];
      pwr  = !disc && POWER_EN && (code == 4'd2);
      eat  = !disc && ((code == 4'd1) || pwr);
      w0 = wr_count;
      p0 = pulse_count;
      tile_valid = 1'b1;
      tile_x = 5'(x);
      tile_y = 6'(y);
      tick();
      tile_valid = 1'b0;
      if (disc) begin
         check("disc_ready", tile_ready, 1);
         tick();
         check("disc_nowrite", wr_count - w0, 0);
         check("disc_score", score, ref_score);
         check("disc_left", pellets_left, ref_left);
         return;
      end
      check("rd_addr", bram_addr, a);
      check("rd_busy", tile_ready, 0);
      tick();
      tick();
      if (eat) begin
         pts = pwr ? 50 : 10;
         ref_score = (ref_score + pts > 65535) ? 65535 : ref_score + pts;
         if (ref_left > 0) ref_left--;
         ref_map[a] = '0;
         check("wr_we", bram_we, 1);
         check("wr_addr", bram_addr, a);
         check("wr_data", bram_wdata, 0);
         check("wr_pulse", power_pulse, pwr);
         check("eat_score", score, ref_score);
         check("eat_left", pellets_left, ref_left);
         check("wr_busy", tile_ready, 0);
         tick();
         if (ref_left == 0) begin
            check("done_clear", level_clear, 1);
            check("done_ready", tile_ready, 0);
         end else begin
            check("eat_ready", tile_ready, 1);
         end
         check("eat_one_write", wr_count - w0, 1);
         check("eat_pulses", pulse_count - p0, pwr);
      end else begin
         check("skip_ready", tile_ready, 1);
         check("skip_we", bram_we, 0);
         check("skip_pulse", power_pulse, 0);
         check("skip_score", score, ref_score);
         check("skip_left", pellets_left, ref_left);
         tick();
         check("skip_nowrite", wr_count - w0, 0);
      end
   endtask

   initial begin
      int npel, a, w0, s0, diffs, r;
      rst_n = 1'b0;
      start_level = 1'b0;
      tile_valid = 1'b0;
      tile_x = '0;
      tile_y = '0;

      // level image: exactly TOTAL counted pellets, four power tiles, random other codes
      for (int i = 0; i < DEPTH; i++) begin
         r = $urandom_range(0, 13);
         init_map[i] = (r == 0) ? 4'd0 : 4'(r + 2);
      end
      npel = POWER_EN ? TOTAL - 4 : TOTAL;
      init_map[31] = 4'd1;
      for (int k = 0; k < npel - 1; k++) init_map[100 + 3 * k] = 4'd1;
      init_map[85] = 4'd2;
      init_map[200] = 4'd2;
      init_map[500] = 4'd2;
      init_map[800] = 4'd2;

      repeat (3) tick();
      check_reset("rst");
      rst_n = 1'b1;
      repeat (4) tick();
      check("idle_ready", tile_ready, 0);
      check("idle_srst", srst_count, 0);

      pulse_start("lvl1");
      send_tile(3, 1);
      send_tile(3, 1);
      send_tile(1, 3);
      send_tile(30, $urandom_range(0, 5));
      send_tile(27, 37);
      repeat (150) send_tile($urandom_range(0, 31), $urandom_range(0, 40));

      // walk every tile until the level is cleared
      for (int y = 0; y < 37; y++)
         for (int x = 0; x < COLS; x++)
            if (ref_left > 0) send_tile(x, y);
      check("sweep_left", ref_left, 0);
      check("sweep_clear", level_clear, 1);
      diffs = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_map[i]) diffs++;
      check("bram_image", diffs, 0);

      // DONE ignores requests
      w0 = wr_count;
      tile_valid = 1'b1;
      tile_x = 5'd3;
      tile_y = 6'd1;
      repeat (4) tick();
      tile_valid = 1'b0;
      tick();
      check("done_nowrite", wr_count - w0, 0);
      check("done_hold_ready", tile_ready, 0);
      check("done_hold_clear", level_clear, 1);
      check("done_score", score, ref_score);

      pulse_start("lvl2");
      repeat (30) send_tile($urandom_range(0, 31), $urandom_range(0, 40));

      // abort while the read is in flight
      a = -1;
      for (int i = 0; i < DEPTH; i++) if (ref_map[i] == 4'd1 && a < 0) a = i;
      wait_ready();
      w0 = wr_count;
      tile_valid = 1'b1;
      tile_x = 5'(a % COLS);
      tile_y = 6'(a / COLS);
      tick();
      tile_valid = 1'b0;
      check("abort_rd_addr", bram_addr, a);
      start_level = 1'b1;
      tick();
      start_level = 1'b0;
      after_clear("abort");
      check("abort_nowrite", wr_count - w0, 0);
      check("abort_score", score, ref_score);
      send_tile(a % COLS, a / COLS);

      // reset in the middle of the reload wait
      start_level = 1'b1;
      tick();
      start_level = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0;
      tick();
      check_reset("rst_init");
      rst_n = 1'b1;
      ref_score = 0;
      ref_left = 0;
      s0 = srst_count;
      repeat (DEPTH + 50) tick();
      check("post_rst_ready", tile_ready, 0);
      check("post_rst_srst", srst_count - s0, 0);
      check("post_rst_score", score, ref_score);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
